// File: rtl/axi_ax_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_ax_rr_arbiter
//
// N-to-1 arbiter for an AXI address channel (AW or AR) that also carries the
// IOMMU stream-ID / substream-valid sideband. Selection is round-robin
// (PRIO_MODE=0) or fixed priority, lowest index first (PRIO_MODE=1). Once a
// beat is presented downstream and stalled, the grant is locked to that
// requester until the beat is accepted, so a presented beat is never
// switched or dropped.
//
// Optional feature (compile-time macro AXI_ARB_STARVE_CNT_EN):
//   Each requester has a saturating wait counter. When the arbiter is not
//   locked and a valid requester has waited STARVE_LIMIT cycles, the lowest
//   such index wins regardless of mode, and starve_o is raised. With the
//   macro undefined the counters are absent and starve_o is tied low.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   in_valid_i     per-requester Ax valid          [NUM_REQ]
//   in_ready_o     per-requester Ax ready          [NUM_REQ]
//   in_payload_i   packed payloads, slice i = req i [NUM_REQ*PAYLOAD_WIDTH]
//   in_sid_i       packed stream IDs               [NUM_REQ*SID_WIDTH]
//   in_ssidv_i     per-requester substream valid   [NUM_REQ]
//   out_valid_o    downstream Ax valid
//   out_ready_i    downstream Ax ready
//   out_payload_o  selected payload (0 when nothing is presented)
//   out_sid_o      selected stream ID (0 when nothing is presented)
//   out_ssidv_o    selected substream valid (0 when nothing is presented)
//   out_sel_o      index of the granted requester (holds last when idle)
//   starve_o       starvation override active this cycle
// -----------------------------------------------------------------------------

// Protocol checker: a requester may not drop valid while its beat is locked,
// and at most one requester is ever readied.
module axi_ax_rr_arbiter_chk #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2
) (
    input logic               clk_i,
    input logic               rst_ni,
    input logic               lock_q,
    input logic [SEL_W-1:0]   lock_idx_q,
    input logic [NUM_REQ-1:0] in_valid_i,
    input logic [NUM_REQ-1:0] in_ready_o
);

    a_locked_valid_held : assert property (
        @(posedge clk_i) disable iff (!rst_ni) lock_q |-> in_valid_i[lock_idx_q]
    );

    a_ready_onehot : assert property (
        @(posedge clk_i) disable iff (!rst_ni) $onehot0(in_ready_o)
    );

endmodule

module axi_ax_rr_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int PAYLOAD_WIDTH = 64,
    parameter int SID_WIDTH     = 24,
    parameter int PRIO_MODE     = 0,
    parameter int STARVE_LIMIT  = 15
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_REQ-1:0]                 in_valid_i,
    output logic [NUM_REQ-1:0]                 in_ready_o,
    input  logic [NUM_REQ*PAYLOAD_WIDTH-1:0]   in_payload_i,
    input  logic [NUM_REQ*SID_WIDTH-1:0]       in_sid_i,
    input  logic [NUM_REQ-1:0]                 in_ssidv_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [PAYLOAD_WIDTH-1:0]           out_payload_o,
    output logic [SID_WIDTH-1:0]               out_sid_o,
    output logic                               out_ssidv_o,
    output logic [$clog2(NUM_REQ)-1:0]         out_sel_o,
    output logic                               starve_o
);

    localparam int SEL_W = $clog2(NUM_REQ);

    // Architectural state.
    logic [SEL_W-1:0]   rr_ptr_q;
    logic               lock_q;
    // Also remembers the last presented index so out_sel_o holds when idle.
    logic [SEL_W-1:0]   lock_idx_q;

    logic [SEL_W-1:0]   mode_idx_s;
    logic [SEL_W-1:0]   grant_s;
    logic               any_valid_s;
    logic               out_valid_s;
    logic               handshake_s;
    logic [NUM_REQ-1:0] in_ready_s;
    logic               starve_s;
    logic [SEL_W-1:0]   starve_idx_s;

    // Index reached k steps after ptr, wrapping modulo NUM_REQ.
    function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] ptr, input int k);
        int sum;
        sum = int'(ptr) + k;
        sum = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
        return SEL_W'(sum);
    endfunction

    // Next index after a granted one, NUM_REQ-1 wraps to 0.
    function automatic logic [SEL_W-1:0] next_index(input logic [SEL_W-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? {SEL_W{1'b0}} : (idx + SEL_W'(1));
    endfunction

    assign any_valid_s = |in_valid_i;

    // Mode-based candidate: descending scans so the best match is written last.
    always_comb begin
        mode_idx_s = lock_idx_q;
        if (PRIO_MODE != 0) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                mode_idx_s = in_valid_i[i] ? SEL_W'(i) : mode_idx_s;
            end
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                mode_idx_s = in_valid_i[rr_index(rr_ptr_q, k)] ? rr_index(rr_ptr_q, k) : mode_idx_s;
            end
        end
    end

`ifdef AXI_ARB_STARVE_CNT_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]   wait_cnt_q [NUM_REQ];
    logic [NUM_REQ-1:0] starve_hit_s;

    // Only a requester that is still valid can claim the override.
    always_comb begin
        starve_idx_s = {SEL_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            starve_hit_s[i] = in_valid_i[i] & (wait_cnt_q[i] == CNT_W'(STARVE_LIMIT));
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            starve_idx_s = starve_hit_s[i] ? SEL_W'(i) : starve_idx_s;
        end
        starve_s = ~lock_q & (|starve_hit_s);
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_wait_cnt
        // Saturating wait counter; cleared when idle or when served.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wait_cnt_q[g] <= {CNT_W{1'b0}};
            end else if (!in_valid_i[g] || in_ready_s[g]) begin
                wait_cnt_q[g] <= {CNT_W{1'b0}};
            end else if (wait_cnt_q[g] != CNT_W'(STARVE_LIMIT)) begin
                wait_cnt_q[g] <= wait_cnt_q[g] + CNT_W'(1);
            end else begin
                wait_cnt_q[g] <= wait_cnt_q[g];
            end
        end
    end
`else
    assign starve_s     = 1'b0;
    assign starve_idx_s = {SEL_W{1'b0}};
`endif

    // Final grant: lock beats starvation, starvation beats the mode choice.
    always_comb begin
        if (lock_q) begin
            grant_s = lock_idx_q;
        end else if (starve_s) begin
            grant_s = starve_idx_s;
        end else if (any_valid_s) begin
            grant_s = mode_idx_s;
        end else begin
            grant_s = lock_idx_q;
        end
    end

    assign out_valid_s = in_valid_i[grant_s];
    assign handshake_s = out_valid_s & out_ready_i;

    // Ready reaches only the granted requester, and only when it is presenting.
    always_comb begin
        if (handshake_s) begin
            in_ready_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_s;
        end else begin
            in_ready_s = {NUM_REQ{1'b0}};
        end
    end

    // Output mux; sideband is zeroed whenever no beat is presented.
    always_comb begin
        if (out_valid_s) begin
            out_payload_o = in_payload_i[int'(grant_s)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            out_sid_o     = in_sid_i[int'(grant_s)*SID_WIDTH +: SID_WIDTH];
            out_ssidv_o   = in_ssidv_i[grant_s];
        end else begin
            out_payload_o = {PAYLOAD_WIDTH{1'b0}};
            out_sid_o     = {SID_WIDTH{1'b0}};
            out_ssidv_o   = 1'b0;
        end
    end

    assign out_valid_o = out_valid_s;
    assign in_ready_o  = in_ready_s;
    assign out_sel_o   = grant_s;
    assign starve_o    = starve_s;

    // Lock / pointer update: stall locks, handshake unlocks and advances RR.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= {SEL_W{1'b0}};
            lock_q     <= 1'b0;
            lock_idx_q <= {SEL_W{1'b0}};
        end else if (handshake_s) begin
            lock_q     <= 1'b0;
            lock_idx_q <= grant_s;
            rr_ptr_q   <= (PRIO_MODE == 0) ? next_index(grant_s) : rr_ptr_q;
        end else if (out_valid_s) begin
            lock_q     <= 1'b1;
            lock_idx_q <= grant_s;
            rr_ptr_q   <= rr_ptr_q;
        end else begin
            lock_q     <= lock_q;
            lock_idx_q <= lock_idx_q;
            rr_ptr_q   <= rr_ptr_q;
        end
    end

`ifndef SYNTHESIS
    axi_ax_rr_arbiter_chk #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_chk (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .lock_q     (lock_q),
        .lock_idx_q (lock_idx_q),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_s)
    );
`endif

endmodule
